// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a word-wide data port through an arbiter.
// Define LSU_RMW_EN to perform sub-word stores as read-merge-write; otherwise they complete with an error.
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lsuReq,
  input  logic              lsuWr,
  input  logic [1:0]        lsuSize,
  input  logic              lsuUnsigned,
  input  logic [ADDR_W-1:0] lsuAddr,
  input  logic [DATA_W-1:0] lsuWData,
  output logic              lsuBusy,
  output logic              lsuDone,
  output logic              lsuErr,
  output logic [DATA_W-1:0] lsuRData,
  output logic              reqD,
  output logic              wr,
  output logic [ADDR_W-1:0] memDAddr,
  output logic [DATA_W-1:0] memDData,
  input  logic              memDReady,
  input  logic [DATA_W-1:0] memDataOutReg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_WR    = 3'd2,
    S_DONE  = 3'd3
`ifdef LSU_RMW_EN
    , S_MERGE = 3'd4
`endif
  } state_t;

  state_t              state_q;
  logic                busy_q, done_q, err_q, err_pend_q;
  logic                req_q, wr_q, mem_wr_q, uns_q;
  logic [1:0]          size_q, off_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, word_q, rdata_q;

  logic                acc_err;
  logic [DATA_W-1:0]   ld_data;
  logic [7:0]          byte_sel;
  logic [15:0]         half_sel;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    acc_err = 1'b0;
    case (lsuSize)
      2'b00:   acc_err = 1'b0;
      2'b01:   acc_err = lsuAddr[0];
      2'b10:   acc_err = |lsuAddr[1:0];
      default: acc_err = 1'b1;
    endcase
`ifndef LSU_RMW_EN
    if (lsuWr && lsuSize != 2'b10) acc_err = 1'b1;
`endif
  end

  // Little-endian lane selection from the captured word, then extension.
  always_comb begin
    byte_sel = word_q[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? word_q[31:16] : word_q[15:0];
    case (size_q)
      2'b00:   ld_data = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   ld_data = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ld_data = word_q;
    endcase
  end

`ifdef LSU_RMW_EN
  logic [DATA_W-1:0] merged;

  always_comb begin
    merged = word_q;
    if (size_q == 2'b00) merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else                 merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only; the capture
  // registers are reset as well so every output is defined out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
      req_q      <= 1'b0;
      mem_wr_q   <= 1'b0;
      wr_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b00;
      off_q      <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      word_q     <= '0;
      rdata_q    <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (lsuReq) begin
            addr_q     <= {lsuAddr[ADDR_W-1:2], 2'b00};
            off_q      <= lsuAddr[1:0];
            size_q     <= lsuSize;
            wr_q       <= lsuWr;
            uns_q      <= lsuUnsigned;
            wdata_q    <= lsuWData;
            busy_q     <= 1'b1;
            err_pend_q <= acc_err;
            if (acc_err) begin
              state_q <= S_DONE;
            end else if (lsuWr && lsuSize == 2'b10) begin
              state_q  <= S_WR;
              req_q    <= 1'b1;
              mem_wr_q <= 1'b1;
            end else begin
              state_q  <= S_RD;
              req_q    <= 1'b1;
              mem_wr_q <= 1'b0;
            end
          end
        end
        S_RD: begin
          if (memDReady) begin
            req_q  <= 1'b0;
            word_q <= memDataOutReg;
`ifdef LSU_RMW_EN
            state_q <= wr_q ? S_MERGE : S_DONE;
`else
            state_q <= S_DONE;
`endif
          end
        end
`ifdef LSU_RMW_EN
        // The idle cycle here also keeps reqD low for a cycle between phases.
        S_MERGE: begin
          wdata_q  <= merged;
          req_q    <= 1'b1;
          mem_wr_q <= 1'b1;
          state_q  <= S_WR;
        end
`endif
        S_WR: begin
          if (memDReady) begin
            req_q    <= 1'b0;
            mem_wr_q <= 1'b0;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          err_q   <= err_pend_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (!wr_q && !err_pend_q) rdata_q <= ld_data;
        end
        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          req_q    <= 1'b0;
          mem_wr_q <= 1'b0;
        end
      endcase
    end
  end

  assign lsuBusy  = busy_q;
  assign lsuDone  = done_q;
  assign lsuErr   = err_q;
  assign lsuRData = rdata_q;
  assign reqD     = req_q;
  assign wr       = mem_wr_q;
  assign memDAddr = addr_q;
  assign memDData = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, errors, reset abort, request filtering.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        lsuReq = 1'b0, lsuWr = 1'b0, lsuUnsigned = 1'b0;
  logic [1:0]  lsuSize = 2'b00;
  logic [31:0] lsuAddr = '0, lsuWData = '0;
  logic        lsuBusy, lsuDone, lsuErr, reqD, wr;
  logic [31:0] lsuRData, memDAddr, memDData;
  logic        memDReady = 1'b0;
  logic [31:0] memDataOutReg = '0;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  logic [31:0] exp_rdata = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .lsuReq(lsuReq), .lsuWr(lsuWr), .lsuSize(lsuSize), .lsuUnsigned(lsuUnsigned),
    .lsuAddr(lsuAddr), .lsuWData(lsuWData),
    .lsuBusy(lsuBusy), .lsuDone(lsuDone), .lsuErr(lsuErr), .lsuRData(lsuRData),
    .reqD(reqD), .wr(wr), .memDAddr(memDAddr), .memDData(memDData),
    .memDReady(memDReady), .memDataOutReg(memDataOutReg)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    int          extra;
    logic [31:0] word;
    logic [31:0] exp;
  } vec_t;

  // Called at a negedge; holds lsuReq for exactly one cycle.
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d, output int rc);
    lsuReq = 1'b1; lsuWr = w; lsuSize = sz; lsuUnsigned = u; lsuAddr = a; lsuWData = d;
    rc = cyc;
    @(negedge clk);
    lsuReq = 1'b0;
  endtask

  // Arbiter model: waits for reqD, keeps it pending 'extra' more cycles, then answers.
  task automatic run_mem(input int extra, input logic [31:0] rd_word, output bit ok,
                         output logic [31:0] s_addr, output logic s_wr, output logic [31:0] s_wdata);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (reqD === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    s_addr = memDAddr; s_wr = wr; s_wdata = memDData;
    if (!ok) return;
    repeat (extra) @(negedge clk);
    memDReady = 1'b1; memDataOutReg = rd_word;
    @(negedge clk);
    memDReady = 1'b0; memDataOutReg = '0;
  endtask

  task automatic wait_done(output bit ok, output int dc, output bit req_seen);
    ok = 1'b0; dc = 0; req_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (reqD === 1'b1) req_seen = 1'b1;
      if (lsuDone === 1'b1) begin ok = 1'b1; dc = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    lsuReq = 1'b1; lsuAddr = 32'h40; lsuSize = 2'b10; lsuWData = 32'h1234_5678;
    repeat (2) @(negedge clk);
    n_total++;
    if ({reqD, wr, lsuDone, lsuErr, lsuBusy} !== 5'b0)
      $display("FAIL reset_ctrl: got %b exp 00000", {reqD, wr, lsuDone, lsuErr, lsuBusy});
    else n_pass++;
    n_total++;
    if ({lsuRData, memDAddr, memDData} !== 96'h0)
      $display("FAIL reset_data: got %h %h %h exp zeros", lsuRData, memDAddr, memDData);
    else n_pass++;
    lsuReq = 1'b0; reset = 1'b1;
    @(negedge clk);
    n_total++;
    if (lsuBusy !== 1'b0 || reqD !== 1'b0) $display("FAIL reset_release: busy %b reqD %b exp 0 0", lsuBusy, reqD);
    else n_pass++;
  endtask

  task automatic test_loads();
    vec_t v [8];
    int rc, dc; bit ok, rs; logic [31:0] sa, sd; logic sw;
    v[0] = '{32'h0000_0100, 2'b10, 1'b0, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    v[1] = '{32'h0000_0103, 2'b00, 1'b0, 0, 32'h80FF_1234, 32'hFFFF_FF80};
    v[2] = '{32'h0000_0103, 2'b00, 1'b1, 0, 32'h80FF_1234, 32'h0000_0080};
    v[3] = '{32'h0000_0102, 2'b01, 1'b0, 1, 32'h80FF_1234, 32'hFFFF_80FF};
    v[4] = '{32'h0000_0100, 2'b01, 1'b1, 0, 32'h80FF_1234, 32'h0000_1234};
    v[5] = '{32'h0000_0101, 2'b00, 1'b0, 0, 32'h80FF_1234, 32'h0000_0012};
    v[6] = '{32'h0000_0A02, 2'b00, 1'b0, 0, 32'h00AB_0000, 32'hFFFF_FFAB};
    v[7] = '{32'hFFFF_FFFE, 2'b01, 1'b0, 0, 32'h7FFF_0000, 32'h0000_7FFF};
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, v[i].size, v[i].uns, v[i].addr, 32'h0, rc);
      n_total++;
      if (lsuBusy !== 1'b1 || wr !== 1'b0) $display("FAIL load[%0d] busy/wr: got %b %b exp 1 0", i, lsuBusy, wr);
      else n_pass++;
      run_mem(v[i].extra, v[i].word, ok, sa, sw, sd);
      n_total++;
      if (!ok || sa !== {v[i].addr[31:2], 2'b00} || sw !== 1'b0)
        $display("FAIL load[%0d] mem: ok %b addr %h wr %b exp addr %h wr 0", i, ok, sa, sw, {v[i].addr[31:2], 2'b00});
      else n_pass++;
      n_total++;
      if (reqD !== 1'b0) $display("FAIL load[%0d] reqD_drop: got %b exp 0", i, reqD);
      else n_pass++;
      wait_done(ok, dc, rs);
      exp_rdata = v[i].exp;
      n_total++;
      if (!ok || lsuRData !== exp_rdata || lsuErr !== 1'b0)
        $display("FAIL load[%0d] data: done %b rdata %h err %b exp %h err 0", i, ok, lsuRData, lsuErr, exp_rdata);
      else n_pass++;
      n_total++;
      if (dc - rc !== v[i].extra + 3) $display("FAIL load[%0d] latency: got %0d exp %0d", i, dc - rc, v[i].extra + 3);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (lsuDone !== 1'b0 || lsuBusy !== 1'b0 || lsuRData !== exp_rdata)
        $display("FAIL load[%0d] after: done %b busy %b rdata %h exp 0 0 %h", i, lsuDone, lsuBusy, lsuRData, exp_rdata);
      else n_pass++;
    end
  endtask

  task automatic test_word_store();
    int rc, dc; bit ok, rs; logic [31:0] sa, sd; logic sw;
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0304, 32'hCAFE_F00D, rc);
    run_mem(1, 32'h0, ok, sa, sw, sd);
    n_total++;
    if (!ok || sa !== 32'h304 || sw !== 1'b1 || sd !== 32'hCAFE_F00D)
      $display("FAIL wstore mem: ok %b addr %h wr %b data %h exp 304 1 cafef00d", ok, sa, sw, sd);
    else n_pass++;
    wait_done(ok, dc, rs);
    n_total++;
    if (!ok || lsuErr !== 1'b0 || dc - rc !== 4 || lsuRData !== exp_rdata)
      $display("FAIL wstore done: ok %b err %b lat %0d rdata %h exp 1 0 4 %h", ok, lsuErr, dc - rc, lsuRData, exp_rdata);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_subword_store();
    vec_t v [4];
    int rc, dc; bit ok, rs; logic [31:0] sa, sd; logic sw;
    v[0] = '{32'h0000_0202, 2'b01, 1'b0, 0, 32'h1122_3344, 32'hABCD_3344};
    v[1] = '{32'h0000_0201, 2'b00, 1'b0, 0, 32'hAABB_CCDD, 32'hAABB_5ADD};
    v[2] = '{32'h0000_0200, 2'b01, 1'b0, 0, 32'h1122_3344, 32'h1122_BEEF};
    v[3] = '{32'h0000_0203, 2'b00, 1'b0, 0, 32'h1122_3344, 32'h9922_3344};
    for (int i = 0; i < 4; i++) begin
      logic [31:0] wd;
      wd = (i == 0) ? 32'h1234_ABCD : (i == 1) ? 32'hFFFF_FF5A : (i == 2) ? 32'h0000_BEEF : 32'h0000_0099;
      issue(1'b1, v[i].size, 1'b0, v[i].addr, wd, rc);
`ifdef LSU_RMW_EN
      run_mem(0, v[i].word, ok, sa, sw, sd);
      n_total++;
      if (!ok || sa !== {v[i].addr[31:2], 2'b00} || sw !== 1'b0)
        $display("FAIL sstore[%0d] read: ok %b addr %h wr %b exp wr 0", i, ok, sa, sw);
      else n_pass++;
      n_total++;
      if (reqD !== 1'b0) $display("FAIL sstore[%0d] gap: reqD %b exp 0", i, reqD);
      else n_pass++;
      run_mem(0, 32'h0, ok, sa, sw, sd);
      n_total++;
      if (!ok || sa !== {v[i].addr[31:2], 2'b00} || sw !== 1'b1 || sd !== v[i].exp)
        $display("FAIL sstore[%0d] write: ok %b addr %h wr %b data %h exp %h", i, ok, sa, sw, sd, v[i].exp);
      else n_pass++;
      wait_done(ok, dc, rs);
      n_total++;
      if (!ok || lsuErr !== 1'b0) $display("FAIL sstore[%0d] done: ok %b err %b exp 1 0", i, ok, lsuErr);
      else n_pass++;
`else
      wait_done(ok, dc, rs);
      n_total++;
      if (!ok || lsuErr !== 1'b1 || rs !== 1'b0 || dc - rc !== 2)
        $display("FAIL sstore[%0d] err: ok %b err %b reqD_seen %b lat %0d exp 1 1 0 2", i, ok, lsuErr, rs, dc - rc);
      else n_pass++;
`endif
      @(negedge clk);
    end
  endtask

  task automatic test_errors();
    vec_t v [4];
    int rc, dc; bit ok, rs;
    v[0] = '{32'h0000_0101, 2'b10, 1'b0, 0, 32'h0, 32'h0};
    v[1] = '{32'h0000_0102, 2'b10, 1'b1, 0, 32'h0, 32'h0};
    v[2] = '{32'h0000_0103, 2'b01, 1'b0, 0, 32'h0, 32'h0};
    v[3] = '{32'h0000_0000, 2'b11, 1'b0, 0, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      // uns field doubles as the write flag for these vectors
      issue(v[i].uns, v[i].size, 1'b0, v[i].addr, 32'h5555_AAAA, rc);
      wait_done(ok, dc, rs);
      n_total++;
      if (!ok || lsuErr !== 1'b1 || rs !== 1'b0 || dc - rc !== 2)
        $display("FAIL err[%0d]: ok %b err %b reqD_seen %b lat %0d exp 1 1 0 2", i, ok, lsuErr, rs, dc - rc);
      else n_pass++;
      n_total++;
      if (lsuRData !== exp_rdata) $display("FAIL err[%0d] rdata_hold: got %h exp %h", i, lsuRData, exp_rdata);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int rc, dc, bad; bit ok, rs; logic [31:0] sa, sd; logic sw;
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h0000_0077, rc);
    n_total++;
    if (reqD !== 1'b1 || wr !== 1'b1) $display("FAIL rstmid wr_phase: reqD %b wr %b exp 1 1", reqD, wr);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_total++;
    if (reqD !== 1'b0 || lsuBusy !== 1'b0 || lsuDone !== 1'b0)
      $display("FAIL rstmid abort: reqD %b busy %b done %b exp 0 0 0", reqD, lsuBusy, lsuDone);
    else n_pass++;
    reset = 1'b1;
    exp_rdata = 32'h0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (lsuDone !== 1'b0 || reqD !== 1'b0 || lsuBusy !== 1'b0) bad++;
    end
    n_total++;
    if (bad !== 0 || lsuRData !== exp_rdata) $display("FAIL rstmid quiet: bad %0d rdata %h exp 0 0", bad, lsuRData);
    else n_pass++;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, rc);
    run_mem(0, 32'h0102_0304, ok, sa, sw, sd);
    wait_done(ok, dc, rs);
    exp_rdata = 32'h0102_0304;
    n_total++;
    if (!ok || lsuRData !== exp_rdata || lsuErr !== 1'b0 || dc - rc !== 3)
      $display("FAIL rstmid reload: ok %b rdata %h err %b lat %0d exp %h 0 3", ok, lsuRData, lsuErr, dc - rc, exp_rdata);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_req_during_rd();
    int rc, dc, extra_done, extra_req; bit ok, rs; logic [31:0] sa, sd; logic sw;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, rc);
    lsuReq = 1'b1; lsuWr = 1'b1; lsuSize = 2'b00; lsuAddr = 32'h0000_0601; lsuWData = 32'hFFFF_FFFF;
    @(negedge clk);
    lsuReq = 1'b0;
    run_mem(0, 32'h5566_7788, ok, sa, sw, sd);
    n_total++;
    if (!ok || sa !== 32'h500 || sw !== 1'b0) $display("FAIL busyreq mem: ok %b addr %h wr %b exp 500 0", ok, sa, sw);
    else n_pass++;
    lsuReq = 1'b1; lsuWr = 1'b0; lsuSize = 2'b10; lsuAddr = 32'h0000_0700;
    wait_done(ok, dc, rs);
    lsuReq = 1'b0;
    exp_rdata = 32'h5566_7788;
    n_total++;
    if (!ok || lsuRData !== exp_rdata || lsuErr !== 1'b0)
      $display("FAIL busyreq data: ok %b rdata %h err %b exp %h 0", ok, lsuRData, lsuErr, exp_rdata);
    else n_pass++;
    extra_done = 0; extra_req = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (lsuDone === 1'b1) extra_done++;
      if (reqD === 1'b1 || lsuBusy === 1'b1) extra_req++;
    end
    n_total++;
    if (extra_done !== 0 || extra_req !== 0)
      $display("FAIL busyreq ignored: extra done %0d activity %0d exp 0 0", extra_done, extra_req);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int rc, dc; bit ok, rs; logic [31:0] sa, sd; logic sw;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0800, 32'h0, rc);
    run_mem(0, 32'h0BAD_F00D, ok, sa, sw, sd);
    wait_done(ok, dc, rs);
    exp_rdata = 32'h0BAD_F00D;
    n_total++;
    if (!ok || lsuRData !== exp_rdata) $display("FAIL b2b first: ok %b rdata %h exp %h", ok, lsuRData, exp_rdata);
    else n_pass++;
    issue(1'b0, 2'b00, 1'b1, 32'h0000_0802, 32'h0, rc);
    n_total++;
    if (lsuBusy !== 1'b1 || lsuRData !== exp_rdata)
      $display("FAIL b2b accept: busy %b rdata %h exp 1 %h", lsuBusy, lsuRData, exp_rdata);
    else n_pass++;
    run_mem(0, 32'h00C3_0000, ok, sa, sw, sd);
    wait_done(ok, dc, rs);
    exp_rdata = 32'h0000_00C3;
    n_total++;
    if (!ok || lsuRData !== exp_rdata || dc - rc !== 3)
      $display("FAIL b2b second: ok %b rdata %h lat %0d exp %h 3", ok, lsuRData, dc - rc, exp_rdata);
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_loads();
    test_word_store();
    test_subword_store();
    test_errors();
    test_reset_mid();
    test_req_during_rd();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address width on both the core and memory sides.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width; only 32 is supported.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be a synchronous, active-low reset sampled on rising clk.
REQ-005 lsuReq  in  1  SHALL be the core request strobe, accepted only in IDLE.
REQ-006 lsuWr  in  1  SHALL select the access type: 1 = store, 0 = load.
REQ-007 lsuSize  in  2  SHALL give the access size: 00 = byte, 01 = half, 10 = word; 11 is an error.
REQ-008 lsuUnsigned  in  1  SHALL select load extension: 1 = zero-extend, 0 = sign-extend.
REQ-009 lsuAddr  in  ADDR_W  SHALL carry the byte address.
REQ-010 lsuWData  in  DATA_W  SHALL carry store data, right-justified.
REQ-011 lsuBusy  out  1  SHALL be high whenever the FSM is not in IDLE.
REQ-012 lsuDone  out  1  SHALL give a one-cycle completion pulse.
REQ-013 lsuErr  out  1  SHALL be valid with lsuDone and flag a misaligned, unsupported or illegal-size access.
REQ-014 lsuRData  out  DATA_W  SHALL carry extended load data, valid with lsuDone and held until the next lsuDone.
REQ-015 reqD  out  1  SHALL be the data-port request to the arbiter.
REQ-016 wr  out  1  SHALL be the arbiter write enable.
REQ-017 memDAddr  out  ADDR_W  SHALL carry the word-aligned address {lsuAddr[ADDR_W-1:2],2'b00}.
REQ-018 memDData  out  DATA_W  SHALL carry the full word to be written.
REQ-019 memDReady  in  1  SHALL be the arbiter completion indication.
REQ-020 memDataOutReg  in  DATA_W  SHALL carry the read word from the arbiter, valid while memDReady is high.

Function
REQ-021 The FSM SHALL have the states IDLE, RD, MERGE, WR and DONE.
REQ-022 In IDLE with lsuReq high, the block SHALL latch the address, size, data, lsuWr and lsuUnsigned.
REQ-023 Misaligned accesses (half with addr[0]=1; word with addr[1:0]!=0) and lsuSize=11 SHALL go IDLE->DONE with lsuErr=1 and no reqD.
REQ-024 Loads SHALL go IDLE->RD; word stores SHALL go IDLE->WR; sub-word stores SHALL go IDLE->RD->MERGE->WR.
REQ-025 In RD or WR, reqD SHALL be held high, with wr=0 in RD and wr=1 in WR, until memDReady is sampled high.
REQ-026 On sampling memDReady, reqD SHALL drop on the next edge.
REQ-027 RD SHALL then go to MERGE for a sub-word store, or to DONE for a load, with memDataOutReg captured.
REQ-028 Before the FSM leaves IDLE for the next memory phase, reqD SHALL have been low for at least one cycle (the arbiter's memDReady is level-held).
REQ-029 Byte lanes SHALL be little-endian: byte n occupies bits [8n+7:8n].
REQ-030 A load SHALL select the byte using addr[1:0] and the half using addr[1], then sign- or zero-extend to 32 bits.
REQ-031 MERGE (one cycle) SHALL replace only the addressed byte or half of the captured word with lsuWData[7:0] or [15:0]; all other bytes are unchanged.
REQ-032 DONE SHALL pulse lsuDone for one cycle and return to IDLE; lsuReq in that cycle SHALL be ignored.
REQ-033 lsuReq while busy SHALL be ignored; inputs SHALL NOT be re-sampled mid-operation.
REQ-034 Latency SHALL be measured from the lsuReq cycle to the lsuDone cycle:
- word store = memDReady wait + 2 cycles
- load = memDReady wait + 2 cycles
- error = 2 cycles
REQ-035 Outputs SHALL be registered; there is no combinational path from any input to any output.

Reset
REQ-036 While reset=0 at a clock edge, the block SHALL force:
- FSM = IDLE
- reqD = 0, wr = 0, lsuDone = 0, lsuErr = 0, lsuBusy = 0
- lsuRData = 0, memDAddr = 0, memDData = 0
REQ-037 A reset mid-operation SHALL abandon the access without lsuDone; a write already issued to the arbiter is not recalled.

Configuration
REQ-038 With macro LSU_RMW_EN defined, sub-word stores SHALL use the RD->MERGE->WR sequence.
REQ-039 With LSU_RMW_EN undefined, sub-word stores SHALL complete via IDLE->DONE with lsuErr=1 and no memory access; MERGE SHALL be absent from the design.

Verification
REQ-040 Word load at 0x100 with memDataOutReg=0xDEADBEEF after a 3-cycle wait -> lsuRData=0xDEADBEEF, lsuErr=0, lsuDone one cycle.
REQ-041 Signed byte load at 0x103, memory word 0x80FF1234 -> lsuRData=0xFFFFFF80; the same access unsigned -> 0x00000080.
REQ-042 Half store of 0xABCD at 0x202, old word 0x11223344 (LSU_RMW_EN) -> one read, then a write of memDData=0xABCD3344 to 0x200.
REQ-043 Word load at 0x101 -> lsuDone+lsuErr 2 cycles after lsuReq, with reqD never asserted.
REQ-044 reset=0 asserted while in WR with reqD high -> reqD=0, lsuBusy=0 next cycle, no lsuDone; a following word load completes normally.
REQ-045 lsuReq pulsed during RD -> ignored; only one lsuDone results, carrying the first request's data.
